// File: rtl/fir_decim_rescale_if.sv
// Stream bundle between the FIR output, the decimating rescaler and its consumer.
// The producer/consumer side is the master; the rescaler itself is the slave.
interface fir_decim_rescale_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  din;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] dout;
  logic                    drop;
  logic                    sat_flag;

  modport master (
    output in_valid, din, out_ready,
    input  out_valid, dout, drop, sat_flag
  );

  modport slave (
    input  in_valid, din, out_ready,
    output out_valid, dout, drop, sat_flag
  );
endinterface

// File: rtl/fir_decim_rescale.sv
// Integrate-and-dump decimator for the FIR output stream. Each window sum is rounded
// half-up, arithmetically shifted and saturated onto a valid/ready output register.
module fir_decim_rescale #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int ACC_W = IN_W + 4
) (
  input logic clk,
  input logic rst,
  fir_decim_rescale_if.slave bus
);

  localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2 ** (OUT_W-1)));

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W:0]   dinExt;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   scaled;
  logic                    satHi;
  logic                    satLo;
  logic signed [OUT_W-1:0] clipped;
  logic                    winEnd;

  // One extra bit over the accumulator keeps the rounding add from wrapping.
  always_comb begin
    dinExt  = {{(ACC_W+1-IN_W){bus.din[IN_W-1]}}, bus.din};
    sum     = {acc[ACC_W-1], acc} + dinExt;
    rounded = sum + RND;
    scaled  = rounded >>> SHIFT;
    satHi   = scaled > MAXV;
    satLo   = scaled < MINV;
    if (satHi)
      clipped = {1'b0, {(OUT_W-1){1'b1}}};
    else if (satLo)
      clipped = {1'b1, {(OUT_W-1){1'b0}}};
    else
      clipped = scaled[OUT_W-1:0];
    winEnd  = bus.in_valid && (cnt == CNT_W'(DECIM - 1));
  end

  // A finished window either lands in the output register or is dropped when the
  // consumer is still holding off the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      bus.dout      <= '0;
      bus.out_valid <= 1'b0;
      bus.drop      <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else begin
      bus.drop <= 1'b0;
      if (bus.in_valid) begin
        if (winEnd) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum[ACC_W-1:0];
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (winEnd) begin
        if (satHi || satLo)
          bus.sat_flag <= 1'b1;
        if (!bus.out_valid || bus.out_ready) begin
          bus.dout      <= clipped;
          bus.out_valid <= 1'b1;
        end else begin
          bus.drop <= 1'b1;
        end
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_rescale.sv
// Self-checking bench for fir_decim_rescale (DECIM=4, SHIFT=2): window table,
// hand-written handshake/reset sequences, then random traffic against a queue model.
module tb_fir_decim_rescale;

  localparam int DECIM = 4;
  localparam int SHIFT = 2;

  logic clk;
  logic rst;
  int   vecCount;
  int   errCount;

  fir_decim_rescale_if #(.IN_W(16), .OUT_W(8)) bus ();

  fir_decim_rescale #(
    .IN_W(16), .OUT_W(8), .DECIM(DECIM), .SHIFT(SHIFT), .ACC_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d0, d1, d2, d3;
    int expDout;
    bit expSat;
  } winVec_t;

  // Reference model state: samples of the open window and the output register.
  int q[$];
  bit mValid;
  int mDout;
  bit mDrop;
  bit mSat;

  function automatic int rescale(input int s, output bit sat);
    int r;
    r = (s + (1 << (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    return r;
  endfunction

  task automatic modelEdge(input bit r, input bit v, input int d, input bit rdy);
    int s;
    int res;
    bit sat;
    bit newRes;
    if (r) begin
      q.delete();
      mValid = 0; mDout = 0; mDrop = 0; mSat = 0;
    end else begin
      mDrop  = 0;
      newRes = 0;
      res    = 0;
      if (v) begin
        q.push_back(d);
        if (q.size() == DECIM) begin
          s = 0;
          foreach (q[i]) s += q[i];
          q.delete();
          res = rescale(s, sat);
          if (sat) mSat = 1;
          newRes = 1;
        end
      end
      if (newRes) begin
        if (!mValid || rdy) begin mDout = res; mValid = 1; end
        else mDrop = 1;
      end else if (mValid && rdy) begin
        mValid = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int d, input bit rdy);
    rst           = r;
    bus.in_valid  = v;
    bus.din       = 16'(d);
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    modelEdge(r, v, int'($signed(16'(d))), rdy);
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".out_valid"}, int'(bus.out_valid), int'(mValid));
    checkOutput({tag, ".dout"},      int'($signed(bus.dout)), mDout);
    checkOutput({tag, ".drop"},      int'(bus.drop), int'(mDrop));
    checkOutput({tag, ".sat_flag"},  int'(bus.sat_flag), int'(mSat));
  endtask

  winVec_t table_v[$];

  initial begin
    winVec_t w;
    int dArr[4];
    int pat[7];
    bit r, v, rdy;
    logic signed [15:0] ds;

    vecCount = 0;
    errCount = 0;
    rst = 1'b1; bus.in_valid = 1'b0; bus.din = '0; bus.out_ready = 1'b0;

    table_v.push_back('{10, 20, 30, 41, 25, 1'b0});
    table_v.push_back('{-10, -10, -10, -11, -10, 1'b0});
    table_v.push_back('{2, 2, 2, 2, 2, 1'b0});
    table_v.push_back('{-2, -2, -2, -2, -2, 1'b0});
    table_v.push_back('{1, 1, 0, 0, 1, 1'b0});
    table_v.push_back('{-1, -1, 0, 0, 0, 1'b0});
    table_v.push_back('{127, 127, 127, 127, 127, 1'b0});
    table_v.push_back('{-128, -128, -128, -128, -128, 1'b0});
    table_v.push_back('{1000, 1000, 1000, 1000, 127, 1'b1});
    table_v.push_back('{-1000, -1000, -1000, -1000, -128, 1'b1});
    table_v.push_back('{-129, -129, -129, -129, -128, 1'b1});
    table_v.push_back('{128, 128, 128, 128, 127, 1'b1});

    // Reset state
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset.out_valid", int'(bus.out_valid), 0);
    checkOutput("reset.dout", int'($signed(bus.dout)), 0);
    checkOutput("reset.drop", int'(bus.drop), 0);
    checkOutput("reset.sat_flag", int'(bus.sat_flag), 0);

    // Window table, consumer always ready
    for (int t = 0; t < table_v.size(); t++) begin
      w = table_v[t];
      dArr = '{w.d0, w.d1, w.d2, w.d3};
      for (int k = 0; k < DECIM; k++) begin
        applyStimulus(0, 1, dArr[k], 1);
        if (k < DECIM - 1)
          checkOutput($sformatf("tbl%0d.early_valid", t), int'(bus.out_valid), 0);
      end
      checkOutput($sformatf("tbl%0d.out_valid", t), int'(bus.out_valid), 1);
      checkOutput($sformatf("tbl%0d.dout", t), int'($signed(bus.dout)), w.expDout);
      checkOutput($sformatf("tbl%0d.sat_flag", t), int'(bus.sat_flag), int'(w.expSat));
      applyStimulus(0, 0, 0, 1);
      checkOutput($sformatf("tbl%0d.valid_clear", t), int'(bus.out_valid), 0);
    end

    // Backpressure: second result dropped, first held
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < DECIM; k++) applyStimulus(0, 1, 4, 0);
    checkOutput("bp.first_valid", int'(bus.out_valid), 1);
    checkOutput("bp.first_dout", int'($signed(bus.dout)), 4);
    for (int k = 0; k < DECIM; k++) begin
      applyStimulus(0, 1, 8, 0);
      checkOutput($sformatf("bp.drop%0d", k), int'(bus.drop), (k == DECIM - 1) ? 1 : 0);
      checkOutput($sformatf("bp.hold%0d", k), int'($signed(bus.dout)), 4);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("bp.drop_end", int'(bus.drop), 0);
    checkOutput("bp.still_valid", int'(bus.out_valid), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bp.after_xfer_valid", int'(bus.out_valid), 0);
    checkOutput("bp.after_xfer_dout", int'($signed(bus.dout)), 4);

    // Gaps in in_valid never advance the window
    applyStimulus(1, 0, 0, 0);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, pat[k][0], 4, 1);
      checkOutput($sformatf("gap.valid%0d", k), int'(bus.out_valid), (k == 6) ? 1 : 0);
    end
    checkOutput("gap.dout", int'($signed(bus.dout)), 4);

    // Reset mid-window discards the partial sum
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < DECIM; k++) applyStimulus(0, 1, 1000, 1);
    applyStimulus(0, 1, 100, 0);
    applyStimulus(0, 1, 100, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rstmid.out_valid", int'(bus.out_valid), 0);
    checkOutput("rstmid.dout", int'($signed(bus.dout)), 0);
    checkOutput("rstmid.drop", int'(bus.drop), 0);
    checkOutput("rstmid.sat_flag", int'(bus.sat_flag), 0);
    for (int k = 0; k < DECIM; k++) applyStimulus(0, 1, 4, 1);
    checkOutput("rstmid.new_valid", int'(bus.out_valid), 1);
    checkOutput("rstmid.new_dout", int'($signed(bus.dout)), 4);

    // Random traffic against the queue model
    applyStimulus(1, 0, 0, 0);
    checkAll("rnd.reset");
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1)
        ds = 16'($urandom_range(0, 600)) - 16'sd300;
      else
        ds = 16'($urandom());
      applyStimulus(r, v, int'(ds), rdy);
      checkAll($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
